// File: rtl/sede_pkg.sv
// Shared constants, types and helpers for the sede Sobel edge engine.
package sede_pkg;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int PIX_N  = IMG_W * IMG_H;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 10;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_N - 1);

  typedef enum logic {
    LOAD = 1'b0,
    PROC = 1'b1
  } state_t;

  // Zero-extend a pixel into the signed gradient domain.
  function automatic logic signed [GRAD_W-1:0] to_grad(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W - PIX_W){1'b0}}, p});
  endfunction

endpackage

// File: rtl/sede_sobel_core.sv
// Combinational Sobel magnitude: window index = 3*row + col, row 0 on top.
module sede_sobel_core
  import sede_pkg::*;
(
  input  logic [8:0][PIX_W-1:0] win,
  output logic [PIX_W-1:0]      mag
);

  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic        [GRAD_W-1:0] abs_x;
  logic        [GRAD_W-1:0] abs_y;
  logic        [MAG_W-1:0]  sum;

  always_comb begin
    gx = to_grad(win[2]) + (to_grad(win[5]) <<< 1) + to_grad(win[8])
       - to_grad(win[0]) - (to_grad(win[3]) <<< 1) - to_grad(win[6]);
    gy = to_grad(win[6]) + (to_grad(win[7]) <<< 1) + to_grad(win[8])
       - to_grad(win[0]) - (to_grad(win[1]) <<< 1) - to_grad(win[2]);
    abs_x = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
    abs_y = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
    sum   = MAG_W'(abs_x) + MAG_W'(abs_y);
    mag   = (|sum[MAG_W-1:PIX_W]) ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
  end

endmodule

// File: rtl/sede.sv
// Sobel edge engine top: buffers a 32x32 frame, then streams 1024 magnitudes.
module sede
  import sede_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_data,
  output logic             busy,
  output logic             valid,
  output logic [PIX_W-1:0] edge_out
);

  logic [PIX_W-1:0] frame [PIX_N];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             in_vld_reg;
  logic             busy_next, valid_next;
  logic [PIX_W-1:0] edge_next;

  logic             row_lo, row_hi, col_lo, col_hi;
  logic [8:0][PIX_W-1:0] win;
  logic [PIX_W-1:0] mag;

  assign row_lo = (cnt_reg[9:5] == 5'd0);
  assign row_hi = (cnt_reg[9:5] == 5'd31);
  assign col_lo = (cnt_reg[4:0] == 5'd0);
  assign col_hi = (cnt_reg[4:0] == 5'd31);

  // Each tap reads cnt + offset; out-of-frame taps are masked to zero.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    localparam int DY = gi / 3 - 1;
    localparam int DX = gi % 3 - 1;
    localparam logic [CNT_W-1:0] OFS = CNT_W'(DY * IMG_W + DX);
    logic pad;
    assign pad = ((DY < 0) && row_lo) || ((DY > 0) && row_hi) ||
                 ((DX < 0) && col_lo) || ((DX > 0) && col_hi);
    assign win[gi] = pad ? '0 : frame[cnt_reg + OFS];
  end

  sede_sobel_core u_core (
    .win (win),
    .mag (mag)
  );

  always_ff @(posedge clk) begin
    if (state_reg == LOAD && in_vld_reg) begin
      frame[cnt_reg] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= LOAD;
      cnt_reg    <= '0;
      in_vld_reg <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      edge_out   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      in_vld_reg <= ~busy;
      busy       <= busy_next;
      valid      <= valid_next;
      edge_out   <= edge_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (in_vld_reg && cnt_reg == LAST_IDX) state_next = PROC;
      PROC:    if (cnt_reg == LAST_IDX) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    cnt_next   = cnt_reg;
    busy_next  = busy;
    valid_next = 1'b0;
    edge_next  = edge_out;
    case (state_reg)
      LOAD: begin
        busy_next = 1'b0;
        if (in_vld_reg) begin
          if (cnt_reg == LAST_IDX) begin
            cnt_next  = '0;
            busy_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      PROC: begin
        edge_next  = mag;
        valid_next = 1'b1;
        if (cnt_reg == LAST_IDX) begin
          cnt_next  = '0;
          busy_next = 1'b0;
        end else begin
          cnt_next  = cnt_reg + CNT_W'(1);
          busy_next = 1'b1;
        end
      end
      default: begin
        cnt_next  = '0;
        busy_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sede.sv
// Directed bench for sede: frame patterns, protocol behaviour and mid-frame reset.
module tb_sede;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic       busy;
  logic       valid;
  logic [7:0] edge_out;

  int n_checks = 0;
  int n_fail   = 0;
  int img  [1024];
  int expv [1024];
  int res  [1024];
  int last_edge = 0;

  sede dut (
    .clk      (clk),
    .rst      (rst),
    .pix_data (pix_data),
    .busy     (busy),
    .valid    (valid),
    .edge_out (edge_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r > 31 || c < 0 || c > 31) return 0;
    return img[r * 32 + c];
  endfunction

  function automatic int sobel(input int r, input int c);
    int gx, gy, m;
    gx = px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)
       - px(r-1, c-1) - 2*px(r, c-1) - px(r+1, c-1);
    gy = px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1)
       - px(r-1, c-1) - 2*px(r-1, c) - px(r-1, c+1);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic set_img(input int kind);
    for (int i = 0; i < 1024; i++) begin
      case (kind)
        1:       img[i] = 10;
        2:       img[i] = (i % 32 >= 16) ? 50 : 0;
        3:       img[i] = (i % 32 >= 16) ? 200 : 0;
        4:       img[i] = (i == 10*32 + 10) ? 20 : 0;
        default: img[i] = 0;
      endcase
    end
  endtask

  // Present pixels whenever busy is low; caller must be at a negedge.
  task automatic load_pixels(input string name, input int count);
    int t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_wait_load"}, busy, 0);
    for (int n = 0; n < count; n++) begin
      @(posedge clk);
      #1 pix_data = img[n][7:0];
      if (n == 0) begin
        check({name, "_valid_idle"}, valid, 0);
        check({name, "_edge_hold"}, edge_out, last_edge);
      end
    end
  endtask

  task automatic run_frame(input string name);
    int got = 0, bcnt = 0, gaps = 0, cyc = 0;
    bit started = 0;
    for (int i = 0; i < 1024; i++) expv[i] = sobel(i / 32, i % 32);
    load_pixels(name, 1024);
    while (got < 1024 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        bcnt++;
        pix_data = 8'($urandom);
      end
      if (valid) begin
        started = 1;
        res[got] = int'(edge_out);
        check($sformatf("%s_res%0d", name, got), edge_out, expv[got]);
        got++;
      end else if (started) begin
        gaps++;
      end
    end
    check({name, "_count"}, got, 1024);
    check({name, "_busy_cycles"}, bcnt, 1024);
    check({name, "_gaps"}, gaps, 0);
    last_edge = res[1023];
    $display("frame %s: %0d results, busy %0d cycles", name, got, bcnt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_edge", edge_out, 0);
    rst = 1'b1;

    set_img(0);
    run_frame("zero");
    check("zero_mid", res[527], 0);

    set_img(1);
    run_frame("const10");
    check("c10_tl", res[0], 60);
    check("c10_tr", res[31], 60);
    check("c10_bl", res[992], 60);
    check("c10_br", res[1023], 60);
    check("c10_top", res[5], 40);
    check("c10_left", res[160], 40);
    check("c10_bot", res[31*32 + 7], 40);
    check("c10_int", res[10*32 + 10], 0);

    set_img(2);
    run_frame("step50");
    check("s50_c15", res[1*32 + 15], 200);
    check("s50_c16", res[30*32 + 16], 200);
    check("s50_left", res[10*32 + 5], 0);
    check("s50_right", res[10*32 + 25], 0);

    set_img(3);
    run_frame("step200");
    check("s200_c15", res[5*32 + 15], 255);
    check("s200_c16", res[20*32 + 16], 255);

    set_img(4);
    run_frame("impulse");
    check("imp_ctr", res[330], 0);
    check("imp_e", res[331], 40);
    check("imp_n", res[298], 40);
    check("imp_se", res[363], 40);
    check("imp_far0", res[0], 0);
    check("imp_far1", res[700], 0);

    set_img(3);
    run_frame("b2b_a");
    set_img(1);
    run_frame("b2b_b");
    check("b2b_corner", res[1023], 60);

    set_img(3);
    run_frame("pre_rst");
    load_pixels("partial", 500);
    @(posedge clk);
    @(negedge clk);
    check("partial_hold", edge_out, 255);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_edge", edge_out, 0);
    @(negedge clk);
    rst = 1'b1;
    last_edge = 0;
    set_img(4);
    run_frame("after_rst");
    check("after_rst_e", res[331], 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sede.md
# sede

Sobel Edge Detection Engine for a single 32×32, 8-bit grayscale frame. It accepts the frame as a raster-order pixel stream under `busy` flow control and buffers it internally. It then emits 1024 8-bit Sobel gradient magnitudes in raster order, one per cycle, qualified by `valid`. It sits between a pixel source and a result sink that consumes every `valid` cycle.

## Interface
Parameters: none. Constants live in a package.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pix_data`  in  8  input pixel, unsigned.
- `busy`  out  1  registered; high means the source must hold `pix_data` and not advance.
- `valid`  out  1  registered; high means `edge_out` holds one result this cycle.
- `edge_out`  out  8  registered Sobel magnitude.

## Operation
- Source protocol:
  - At each rising edge where `busy` is low, the source presents the next pixel (index 0 first).
  - While `busy` is high, the source holds the current pixel.
- Capture rule:
  - Internal flag `in_vld` resets to 0 and is updated each edge as `in_vld <= ~busy`.
  - In LOAD, `pix_data` is written to `frame[cnt]` at an edge where `in_vld` = 1, then `cnt` increments.
  - Pixel index n = row·32 + col.
- FSM states: LOAD and PROC.
  - LOAD: `busy` = 0, `valid` = 0. Captures pixels.
    - On capturing index 1023: go to PROC, register `busy` = 1, clear `cnt`.
  - PROC: `busy` = 1. Input is ignored.
    - Each edge registers the result for pixel `cnt`, sets `valid` = 1, increments `cnt`.
    - After registering result 1023: return to LOAD, register `busy` = 0, clear `cnt`.
    - The next edge drives `valid` = 0.
  - Consecutive frames are supported. Any pixel launched while the FSM is leaving LOAD is discarded.
- Kernels, applied to the 3×3 window centred on (r,c):
  - Gx = [-1 0 1; -2 0 2; -1 0 1]
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1]
  - Row index increases downward.
- Neighbours outside 0..31 in either axis read as 0 (zero padding).
- Arithmetic:
  - Gx and Gy are 11-bit signed, range ±1020.
  - Magnitude |Gx| + |Gy| is 12-bit unsigned.
  - `edge_out` = min(magnitude, 255).
- Reset (asserted low, asynchronous): state = LOAD; `busy`, `valid`, `edge_out`, `cnt` and `in_vld` are all 0. Frame contents are not reset.
- Reset mid-frame: partial data is abandoned and capture restarts at index 0 after release.

## Timing
- Throughput: one input pixel per cycle in LOAD, one result per cycle in PROC. There are no bubbles inside either phase.
- Let E be the edge that captures pixel 1023.
  - `busy` is high from E.
  - `valid` is high for exactly 1024 consecutive cycles, starting after edge E+1.
  - `busy` falls at the edge that registers result 1023.
  - `valid` falls one edge later.
- `edge_out` holds its last value whenever `valid` = 0.
- `cnt` is 10 bits. Border detection uses `cnt[9:5]` (row) and `cnt[4:0]` (col), each compared against 0 and 31.

## Structure
- Package `sede_pkg`:
  - `IMG_W` = 32, `IMG_H` = 32, `PIX_N` = 1024, `PIX_W` = 8.
  - FSM state enum {LOAD, PROC}.
  - Signed gradient width (11) and magnitude width (12).
- Frame storage: 1024×8 register array in the top module.
- One sub-module, `sede_sobel_core`: purely combinational. It takes the nine window pixels and produces the saturated 8-bit magnitude. The top module gathers the window with zero padding and feeds it in.

## Test plan
- All-zero frame → 1024 `valid` results, all 0. `busy` high for exactly 1024 cycles.
- Constant 10 frame:
  - Four corners → 60.
  - Non-corner border pixels → 40.
  - Interior pixels → 0.
- Columns 0–15 = 0, columns 16–31 = 50:
  - Columns 15 and 16 on rows 1–30 → 200.
  - Other interior pixels → 0.
  - Clamping check with 200 instead of 50: those pixels → 255.
- Single pixel 20 at (10,10), rest 0:
  - (10,10) → 0.
  - (10,11), (9,10) and (11,11) → 40 each.
  - Pixels away from the impulse → 0.
- Protocol:
  - Source changes `pix_data` while `busy` is high → no capture, output unchanged.
  - Two back-to-back frames → 2048 correct results with one LOAD phase between them.
- Reset asserted after 500 captured pixels → `busy`, `valid` and `edge_out` go to 0 immediately. A full new frame then yields the correct 1024 results.
